// File: rtl/id_stage_pkg.sv
// Shared constants, encodings and the decoded-control bundle for the RV32I
// decode stage.
package id_stage_pkg;

  localparam int WORD_LEN = 32;
  localparam int NREG     = 32;
  localparam int RADDR_W  = 5;

  localparam logic [WORD_LEN-1:0] START_ADDR = 32'h0000_0000;
  localparam logic [WORD_LEN-1:0] EXIT_INST  = 32'h3433_3231;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_COPY1 = 4'd10
  } alu_op_e;

  // Operand source select shared by both operand muxes.
  typedef enum logic [1:0] {
    SEL_REG  = 2'd0,
    SEL_PC   = 2'd1,
    SEL_IMM  = 2'd2,
    SEL_ZERO = 2'd3
  } sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    alu_op_e             alu_op;
    sel_e                op1_sel;
    sel_e                op2_sel;
    logic                wb_en;
    logic                mem_ren;
    logic                mem_wen;
    logic                branch;
    logic                jump;
    logic                illegal;
    logic                exit_flag;
    logic [WORD_LEN-1:0] imm;
  } ctrl_t;

  // alt selects SUB/SRA; callers mask it for OP-IMM where bit 30 is immediate.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 2-read / 1-write register file with x0 hardwired to zero and
// same-cycle write-through bypass on both read ports.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [RADDR_W-1:0]  waddr,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [RADDR_W-1:0]  raddr1,
  input  logic [RADDR_W-1:0]  raddr2,
  output logic [WORD_LEN-1:0] rdata1,
  output logic [WORD_LEN-1:0] rdata2
);

  // x0 has no storage; index 0 is intercepted on the read side.
  logic [WORD_LEN-1:0] regs_reg [1:NREG-1];

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          regs_reg[gi] <= '0;
        else if (we && waddr == RADDR_W'(gi))
          regs_reg[gi] <= wdata;
      end
    end
  endgenerate

  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0)
      rdata1 = (we && waddr == raddr1) ? wdata : regs_reg[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0)
      rdata2 = (we && waddr == raddr2) ? wdata : regs_reg[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes the fetched word, reads operands
// and latches the ID/EX register; a RUN/HALT FSM stops fetch on EXIT_INST.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid,
  input  logic [WORD_LEN-1:0] if_pc,
  input  logic [WORD_LEN-1:0] if_inst,
  output logic                if_ready,
  input  logic                ex_stall,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [RADDR_W-1:0]  wb_addr,
  input  logic [WORD_LEN-1:0] wb_data,
  output logic                id_valid,
  output logic [WORD_LEN-1:0] id_pc,
  output logic [WORD_LEN-1:0] id_rs1_data,
  output logic [WORD_LEN-1:0] id_rs2_data,
  output logic [RADDR_W-1:0]  id_rd,
  output logic [WORD_LEN-1:0] id_imm,
  output logic [3:0]          id_alu_op,
  output logic [1:0]          id_op1_sel,
  output logic [1:0]          id_op2_sel,
  output logic                id_wb_en,
  output logic                id_mem_ren,
  output logic                id_mem_wen,
  output logic                id_branch,
  output logic                id_jump,
  output logic                id_illegal,
  output logic                id_exit,
  output logic                halted
);

  state_e              state_reg, state_next;
  ctrl_t               dec;
  ctrl_t               ctrl_reg;
  logic                valid_reg;
  logic [WORD_LEN-1:0] pc_reg, rs1_data_reg, rs2_data_reg;
  logic [RADDR_W-1:0]  rd_reg;
  logic [WORD_LEN-1:0] rs1_data, rs2_data;
  logic                transfer;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [RADDR_W-1:0]  rd, rs1, rs2;
  logic [WORD_LEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];

  assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_u = {if_inst[31:12], 12'b0};
  assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

  assign if_ready = (state_reg == ST_RUN) && !ex_stall;
  assign transfer = if_valid && if_ready;
  assign halted   = (state_reg == ST_HALT);

  id_stage_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.op1_sel = SEL_REG;
    dec.op2_sel = SEL_REG;
    if (if_inst == EXIT_INST) begin
      dec.exit_flag = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec.op1_sel = SEL_ZERO;
          dec.op2_sel = SEL_IMM;
          dec.wb_en   = 1'b1;
          dec.imm     = imm_u;
        end
        OPC_AUIPC: begin
          dec.op1_sel = SEL_PC;
          dec.op2_sel = SEL_IMM;
          dec.wb_en   = 1'b1;
          dec.imm     = imm_u;
        end
        OPC_JAL: begin
          dec.op1_sel = SEL_PC;
          dec.op2_sel = SEL_IMM;
          dec.wb_en   = 1'b1;
          dec.jump    = 1'b1;
          dec.imm     = imm_j;
        end
        OPC_JALR: begin
          dec.op2_sel = SEL_IMM;
          dec.wb_en   = 1'b1;
          dec.jump    = 1'b1;
          dec.imm     = imm_i;
        end
        OPC_BRANCH: begin
          // Compare op chosen by funct3[2:1]; the 01 pair is not a branch.
          dec.imm = imm_b;
          case (funct3[2:1])
            2'b00:   begin dec.alu_op = ALU_SUB;  dec.branch = 1'b1; end
            2'b10:   begin dec.alu_op = ALU_SLT;  dec.branch = 1'b1; end
            2'b11:   begin dec.alu_op = ALU_SLTU; dec.branch = 1'b1; end
            default: dec.illegal = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          if (funct3 == 3'b010) begin
            dec.op2_sel = SEL_IMM;
            dec.wb_en   = 1'b1;
            dec.mem_ren = 1'b1;
            dec.imm     = imm_i;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OPC_STORE: begin
          if (funct3 == 3'b010) begin
            dec.op2_sel = SEL_IMM;
            dec.mem_wen = 1'b1;
            dec.imm     = imm_s;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OPC_OPIMM: begin
          dec.op2_sel = SEL_IMM;
          dec.wb_en   = 1'b1;
          dec.imm     = imm_i;
          dec.alu_op  = alu_dec(funct3, (funct3 == 3'b101) && if_inst[30]);
        end
        OPC_OP: begin
          dec.wb_en  = 1'b1;
          dec.alu_op = alu_dec(funct3, if_inst[30]);
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (rd == '0)
      dec.wb_en = 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_RUN && transfer && dec.exit_flag && !flush)
      state_next = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_RUN;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      pc_reg       <= START_ADDR;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      rd_reg       <= '0;
      ctrl_reg     <= '0;
    end else if (flush) begin
      valid_reg          <= 1'b0;
      ctrl_reg.wb_en     <= 1'b0;
      ctrl_reg.mem_ren   <= 1'b0;
      ctrl_reg.mem_wen   <= 1'b0;
      ctrl_reg.branch    <= 1'b0;
      ctrl_reg.jump      <= 1'b0;
      ctrl_reg.illegal   <= 1'b0;
      ctrl_reg.exit_flag <= 1'b0;
    end else if (ex_stall) begin
      valid_reg <= valid_reg;
    end else if (transfer) begin
      valid_reg    <= 1'b1;
      pc_reg       <= if_pc;
      rs1_data_reg <= rs1_data;
      rs2_data_reg <= rs2_data;
      rd_reg       <= rd;
      ctrl_reg     <= dec;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign id_valid    = valid_reg;
  assign id_pc       = pc_reg;
  assign id_rs1_data = rs1_data_reg;
  assign id_rs2_data = rs2_data_reg;
  assign id_rd       = rd_reg;
  assign id_imm      = ctrl_reg.imm;
  assign id_alu_op   = ctrl_reg.alu_op;
  assign id_op1_sel  = ctrl_reg.op1_sel;
  assign id_op2_sel  = ctrl_reg.op2_sel;
  assign id_wb_en    = ctrl_reg.wb_en;
  assign id_mem_ren  = ctrl_reg.mem_ren;
  assign id_mem_wen  = ctrl_reg.mem_wen;
  assign id_branch   = ctrl_reg.branch;
  assign id_jump     = ctrl_reg.jump;
  assign id_illegal  = ctrl_reg.illegal;
  assign id_exit     = ctrl_reg.exit_flag;

endmodule
